mux_rr_stream: RTL and testbench

MUX_RR_STREAM -- requirements
Module: mux_rr_stream

---
 rtl/mux_rr_stream.sv | 125 ++++++++++++
 tb/tb_mux_rr_stream.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mux_rr_stream.sv
// rtl/mux_rr_stream.sv - N-channel stream mux with round-robin/fixed arbitration and packet lock
module mux_rr_stream #(
    parameter  int N_CH = 4,
    parameter  int W    = 8,
    localparam int SW   = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH-1:0]   in_last,
    output logic [N_CH-1:0]   in_ready,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    output logic [W-1:0]      out_data,
    output logic [SW-1:0]     out_ch,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          out_last_q, out_last_d;
    logic          out_valid_q, out_valid_d;
    logic          lock_q, lock_d;
    logic [SW-1:0] lock_ch_q, lock_ch_d;
    logic [SW-1:0] last_grant_q, last_grant_d;

    logic          load;
    logic          found;
    logic [SW-1:0] grant_idx;
    logic          xfer;
    int            cand;

    // The output register can accept a new beat when empty or draining this cycle.
    assign load = !out_valid_q || out_ready;

    // Arbitration: a locked packet owns the mux, otherwise fixed select or a
    // round-robin search starting just after the last granted channel.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = 0;
        if (lock_q) begin
            if (in_valid[lock_ch_q]) begin
                found     = 1'b1;
                grant_idx = lock_ch_q;
            end
        end else if (mode) begin
            if (int'(sel) < N_CH) begin
                if (in_valid[sel]) begin
                    found     = 1'b1;
                    grant_idx = sel;
                end
            end
        end else begin
            for (int i = 1; i <= N_CH; i++) begin
                cand = int'(last_grant_q) + i;
                if (cand >= N_CH) begin
                    cand = cand - N_CH;
                end
                if (!found && in_valid[cand]) begin
                    found     = 1'b1;
                    grant_idx = SW'(cand);
                end
            end
        end
    end

    // Ready is one-hot on the granted channel, gated by load and held low in reset.
    assign in_ready = (found && load && !rst)
                    ? ({{(N_CH-1){1'b0}}, 1'b1} << grant_idx)
                    : '0;
    assign xfer     = |in_ready;

    // Next-state for the output stage, arbitration pointer and packet lock.
    always_comb begin
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;
        lock_d       = lock_q;
        lock_ch_d    = lock_ch_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            out_data_d   = in_data[int'(grant_idx)*W +: W];
            out_ch_d     = grant_idx;
            out_last_d   = in_last[grant_idx];
            out_valid_d  = 1'b1;
            last_grant_d = grant_idx;
            lock_d       = !in_last[grant_idx];
            lock_ch_d    = grant_idx;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    // State registers; reset points last_grant at the top channel so channel 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            lock_q       <= 1'b0;
            lock_ch_q    <= '0;
            last_grant_q <= SW'(N_CH-1);
        end else begin
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            lock_q       <= lock_d;
            lock_ch_q    <= lock_ch_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// tb/tb_mux_rr_stream.sv - directed self-checking bench for mux_rr_stream
module tb_mux_rr_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] d4;
    logic [3:0]  v4, l4, ir4;
    logic        mode4, ordy4;
    logic [1:0]  sel4;
    logic [7:0]  od4;
    logic [1:0]  oc4;
    logic        ol4, ov4;

    logic [23:0] d3;
    logic [2:0]  v3, l3, ir3;
    logic        mode3, ordy3;
    logic [1:0]  sel3;
    logic [7:0]  od3;
    logic [1:0]  oc3;
    logic        ol3, ov3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_rr_stream #(.N_CH(4), .W(8)) dut4 (
        .clk(clk), .rst(rst), .in_data(d4), .in_valid(v4), .in_last(l4),
        .in_ready(ir4), .mode(mode4), .sel(sel4), .out_data(od4), .out_ch(oc4),
        .out_last(ol4), .out_valid(ov4), .out_ready(ordy4)
    );

    mux_rr_stream #(.N_CH(3), .W(8)) dut3 (
        .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_last(l3),
        .in_ready(ir3), .mode(mode3), .sel(sel3), .out_data(od3), .out_ch(oc3),
        .out_last(ol3), .out_valid(ov3), .out_ready(ordy3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for one edge, release 1ns after a rising edge with all inputs idle.
    task automatic do_reset();
        v4 = '0; l4 = '1; mode4 = 1'b0; sel4 = '0; ordy4 = 1'b1;
        v3 = '0; l3 = '1; mode3 = 1'b0; sel3 = '0; ordy3 = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v4 = 4'b1111; l4 = 4'b1111; ordy4 = 1'b1;
        tick();
        n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ov4); end
        n_checks++; if (od4 !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", od4); end
        n_checks++; if (oc4 !== 2'd0) begin n_fail++; $display("FAIL reset_ch got %0d want 0", oc4); end
        n_checks++; if (ol4 !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", ol4); end
        n_checks++; if (ir4 !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", ir4); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ch [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        v4 = 4'b1111; l4 = 4'b1111; ordy4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (ov4 !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d] got %b want 1", i, ov4); end
            n_checks++; if (oc4 !== exp_ch[i]) begin n_fail++; $display("FAIL rr_ch[%0d] got %0d want %0d", i, oc4, exp_ch[i]); end
            n_checks++; if (od4 !== (8'hA0 + 8'(exp_ch[i]))) begin n_fail++; $display("FAIL rr_data[%0d] got %h want %h", i, od4, 8'hA0 + 8'(exp_ch[i])); end
        end
    endtask

    task automatic test_packet_lock();
        logic [1:0] exp_ch [4]   = '{2'd1, 2'd1, 2'd1, 2'd2};
        logic       exp_last [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] last_in [4]  = '{4'b1101, 4'b1101, 4'b1111, 4'b1111};
        logic [3:0] vld_in [4]   = '{4'b0010, 4'b1111, 4'b1111, 4'b1111};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            v4 = vld_in[i]; l4 = last_in[i];
            if (i == 1) begin
                #1;
                n_checks++; if (ir4 !== 4'b0010) begin n_fail++; $display("FAIL lock_ready got %b want 0010", ir4); end
            end
            tick();
            n_checks++; if (oc4 !== exp_ch[i]) begin n_fail++; $display("FAIL lock_ch[%0d] got %0d want %0d", i, oc4, exp_ch[i]); end
            n_checks++; if (ol4 !== exp_last[i]) begin n_fail++; $display("FAIL lock_last[%0d] got %b want %b", i, ol4, exp_last[i]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        v4 = 4'b1111; l4 = 4'b1111; ordy4 = 1'b1;
        tick();
        ordy4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (ir4 !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 0000", i, ir4); end
            tick();
            n_checks++; if (ov4 !== 1'b1 || od4 !== 8'hA0 || oc4 !== 2'd0) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v=%b d=%h ch=%0d want v=1 d=a0 ch=0", i, ov4, od4, oc4);
            end
        end
        ordy4 = 1'b1;
        #1;
        n_checks++; if (ir4 !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready got %b want 0010", ir4); end
        tick();
        n_checks++; if (oc4 !== 2'd1 || od4 !== 8'hA1) begin n_fail++; $display("FAIL bp_release got ch=%0d d=%h want ch=1 d=a1", oc4, od4); end
        v4 = 4'b0000;
        tick();
        n_checks++; if (ov4 !== 1'b0 || od4 !== 8'hA1) begin n_fail++; $display("FAIL drain got v=%b d=%h want v=0 d=a1", ov4, od4); end
    endtask

    task automatic test_fixed_mode();
        do_reset();
        v4 = 4'b1111; l4 = 4'b1111; mode4 = 1'b1; sel4 = 2'd2; ordy4 = 1'b1;
        #1;
        n_checks++; if (ir4 !== 4'b0100) begin n_fail++; $display("FAIL fixed_ready got %b want 0100", ir4); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (oc4 !== 2'd2 || od4 !== 8'hA2) begin n_fail++; $display("FAIL fixed_ch[%0d] got ch=%0d d=%h want ch=2 d=a2", i, oc4, od4); end
        end
        // mode flips while a beat is held: held beat unchanged, new mode used on release
        ordy4 = 1'b0;
        mode4 = 1'b0;
        tick();
        n_checks++; if (oc4 !== 2'd2 || od4 !== 8'hA2 || ov4 !== 1'b1) begin n_fail++; $display("FAIL mode_hold got ch=%0d d=%h v=%b want ch=2 d=a2 v=1", oc4, od4, ov4); end
        ordy4 = 1'b1;
        tick();
        n_checks++; if (oc4 !== 2'd3) begin n_fail++; $display("FAIL mode_switch_ch got %0d want 3", oc4); end

        v3 = 3'b111; l3 = 3'b111; mode3 = 1'b1; sel3 = 2'd0; ordy3 = 1'b1;
        tick();
        n_checks++; if (ov3 !== 1'b1 || oc3 !== 2'd0 || od3 !== 8'hB0) begin n_fail++; $display("FAIL fixed3_sel0 got v=%b ch=%0d d=%h want v=1 ch=0 d=b0", ov3, oc3, od3); end
        sel3 = 2'd3;
        #1;
        n_checks++; if (ir3 !== 3'b000) begin n_fail++; $display("FAIL fixed3_ready got %b want 000", ir3); end
        tick();
        n_checks++; if (ov3 !== 1'b0 || od3 !== 8'hB0) begin n_fail++; $display("FAIL fixed3_nogrant got v=%b d=%h want v=0 d=b0", ov3, od3); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        v4 = 4'b1000; l4 = 4'b0111; ordy4 = 1'b1;
        tick();
        tick();
        n_checks++; if (oc4 !== 2'd3 || ol4 !== 1'b0 || ov4 !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got ch=%0d last=%b v=%b want ch=3 last=0 v=1", oc4, ol4, ov4); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL midrst_async_valid got %b want 0", ov4); end
        n_checks++; if (ir4 !== 4'b0000) begin n_fail++; $display("FAIL midrst_ready got %b want 0000", ir4); end
        tick();
        rst = 1'b0;
        v4 = 4'b1111; l4 = 4'b1111;
        tick();
        n_checks++; if (oc4 !== 2'd0 || ov4 !== 1'b1) begin n_fail++; $display("FAIL midrst_first_grant got ch=%0d v=%b want ch=0 v=1", oc4, ov4); end
    endtask

    initial begin
        d4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        d3 = {8'hB2, 8'hB1, 8'hB0};
        v4 = '0; l4 = '1; mode4 = 1'b0; sel4 = '0; ordy4 = 1'b1;
        v3 = '0; l3 = '1; mode3 = 1'b0; sel3 = '0; ordy3 = 1'b1;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_fixed_mode();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
